fp_add_sequencer: RTL

FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

---
 rtl/fp_add_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/fp_add_sequencer.sv
// Sequences one IEEE754 single-precision add through an external combinational adder.
// Special operands and exact cancellation are resolved locally without waiting on the adder.
module fp_add_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inValid,
   output logic        inReady,
   input  logic [31:0] inA,
   input  logic [31:0] inB,
   output logic [31:0] addA,
   output logic [31:0] addB,
   input  logic [31:0] addSum,
   output logic        outValid,
   input  logic        outReady,
   output logic [31:0] outSum,
   output logic [15:0] opCount
);

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   state_t      state, stateNext;
   logic [3:0]  settleCnt;
   logic        accept, capture, handshake;
   logic        bypass;
   logic [31:0] bypassSum;

   logic        sA, sB, zA, zB, infA, infB, nanA, nanB;

   // Denormals count as zero, so only the exponent decides zero-ness.
   assign sA   = inA[31];
   assign sB   = inB[31];
   assign zA   = (inA[30:23] == 8'd0);
   assign zB   = (inB[30:23] == 8'd0);
   assign infA = (inA[30:23] == 8'hFF) && (inA[22:0] == 23'd0);
   assign infB = (inB[30:23] == 8'hFF) && (inB[22:0] == 23'd0);
   assign nanA = (inA[30:23] == 8'hFF) && (inA[22:0] != 23'd0);
   assign nanB = (inB[30:23] == 8'hFF) && (inB[22:0] != 23'd0);

   always_comb begin
      bypass    = 1'b1;
      bypassSum = 32'h0;
      if (nanA || nanB || (infA && infB && (sA != sB)))
         bypassSum = 32'h7FC00000;
      else if (infA)
         bypassSum = inA;
      else if (infB)
         bypassSum = inB;
      else if (zA && zB)
         bypassSum = (sA && sB) ? 32'h80000000 : 32'h0;
      else if (zA)
         bypassSum = inB;
      else if (zB)
         bypassSum = inA;
      else if ((inA[30:0] == inB[30:0]) && (sA != sB))
         bypassSum = 32'h0;
      else
         bypass = 1'b0;
   end

   always_comb begin
      stateNext = state;
      accept    = 1'b0;
      capture   = 1'b0;
      handshake = 1'b0;
      case (state)
         IDLE: if (inValid) begin
            accept    = 1'b1;
            stateNext = bypass ? DONE : EVAL;
         end
         EVAL: if (settleCnt == 4'd0) begin
            capture   = 1'b1;
            stateNext = DONE;
         end
         DONE: if (outReady) begin
            handshake = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign inReady  = (state == IDLE) && !reset;
   assign outValid = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         settleCnt <= 4'd0;
         addA      <= 32'h0;
         addB      <= 32'h0;
         outSum    <= 32'h0;
         opCount   <= 16'h0;
      end else begin
         state <= stateNext;
         if (accept) begin
            addA      <= inA;
            addB      <= inB;
            settleCnt <= 4'(SETTLE_CYCLES - 1);
            if (bypass)
               outSum <= bypassSum;
         end
         if ((state == EVAL) && (settleCnt != 4'd0))
            settleCnt <= settleCnt - 4'd1;
         if (capture)
            outSum <= addSum;
         // 16-bit add wraps FFFF -> 0000 naturally.
         if (handshake)
            opCount <= opCount + 16'd1;
      end
   end

endmodule
